// File: rtl/scan_mux_reg.sv
// Purpose : registered NCH:1 WIDTH-bit mux with manual select or auto-scan, tagging each sample with its channel.
// Latency : one cycle from din to dout/out_ch; a select change applies to the capture after the one it coincides with.
// Backpressure: valid/ready; the sample holds while out_valid=1 and out_ready=0, and the scan does not advance while stalled.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   en                capture enable (a held sample still drains when en=0)
//   mode              0 = manual select, 1 = auto-scan
//   sel_in, sel_load  manual select value and its load strobe
//   dwell             auto-scan: accepted samples per channel, minus 1
//   din               channel k at din[k*WIDTH +: WIDTH]
//   out_ready         downstream ready
//   out_valid, dout,  registered sample and its channel tag
//   out_ch
//   sel_cur           current select register
//   sel_err           one-cycle pulse when an out-of-range sel_in load is rejected
//
// SELW must be at least clog2(NCH).
module scan_mux_reg #(
  parameter int WIDTH  = 8,
  parameter int NCH    = 4,
  parameter int SELW   = 2,
  parameter int DWELLW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel_in,
  input  logic                   sel_load,
  input  logic [DWELLW-1:0]      dwell,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       dout,
  output logic [SELW-1:0]        out_ch,
  output logic [SELW-1:0]        sel_cur,
  output logic                   sel_err
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  dout_q,      dout_d;
  logic [SELW-1:0]   out_ch_q,    out_ch_d;
  logic [SELW-1:0]   sel_q,       sel_d;
  logic              sel_err_q,   sel_err_d;
  logic [DWELLW-1:0] cnt_q,       cnt_d;
  logic              mode_q,      mode_d;

  logic              cap;
  logic              sel_in_ok;
  logic              sel_last;
  logic [DWELLW-1:0] cnt_base;
  logic [WIDTH-1:0]  din_sel;

  // Channel slice at the current select; an out-of-range select yields zero.
  always_comb begin
    din_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(sel_q) == k) din_sel = din[k*WIDTH +: WIDTH];
    end
  end

  // Output register: capture when the slot is empty or being drained this cycle.
  always_comb begin
    cap         = en & (~out_valid_q | out_ready);
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_ch_d    = out_ch_q;
    if (cap) begin
      dout_d      = din_sel;
      out_ch_d    = sel_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Select register and dwell counter.
  always_comb begin
    sel_in_ok = int'(sel_in) < NCH;
    sel_last  = int'(sel_q) >= NCH - 1;
    // A mode change restarts the dwell count; the sample accepted in that
    // same cycle is counted from zero, so the first channel gets a full dwell.
    cnt_base  = (mode != mode_q) ? '0 : cnt_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    mode_d    = mode;
    sel_err_d = ~mode & sel_load & ~sel_in_ok;
    if (!mode) begin
      cnt_d = '0;
      if (sel_load && sel_in_ok) sel_d = sel_in;
    end else if (cap) begin
      if (cnt_base == dwell) begin
        cnt_d = '0;
        sel_d = sel_last ? '0 : sel_q + SELW'(1);
      end else begin
        cnt_d = cnt_base + DWELLW'(1);
      end
    end else begin
      cnt_d = cnt_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_ch_q    <= '0;
      sel_q       <= '0;
      sel_err_q   <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_ch_q    <= out_ch_d;
      sel_q       <= sel_d;
      sel_err_q   <= sel_err_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_ch    = out_ch_q;
  assign sel_cur   = sel_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_scan_mux_reg.sv
module tb_scan_mux_reg;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int DW  = 4;
  localparam int N3  = 3;

  logic          clk;
  logic          rst, en, mode, sel_load, out_ready;
  logic [SW-1:0] sel_in;
  logic [DW-1:0] dwell;
  logic [N*W-1:0] din;
  logic          out_valid, sel_err;
  logic [W-1:0]  dout;
  logic [SW-1:0] out_ch, sel_cur;

  logic          b_rst, b_sel_load;
  logic [SW-1:0] b_sel_in;
  logic [N3*W-1:0] b_din;
  logic          b_out_valid, b_sel_err;
  logic [W-1:0]  b_dout;
  logic [SW-1:0] b_out_ch, b_sel_cur;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the outputs should show after each edge.
  int m_valid, m_dout, m_ch, m_sel, m_err, m_cnt, m_mprev;

  scan_mux_reg #(.WIDTH(W), .NCH(N), .SELW(SW), .DWELLW(DW)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .sel_load(sel_load),
    .dwell(dwell), .din(din), .out_ready(out_ready), .out_valid(out_valid),
    .dout(dout), .out_ch(out_ch), .sel_cur(sel_cur), .sel_err(sel_err)
  );

  scan_mux_reg #(.WIDTH(W), .NCH(N3), .SELW(SW), .DWELLW(DW)) u_dut3 (
    .clk(clk), .rst(b_rst), .en(1'b1), .mode(1'b0), .sel_in(b_sel_in), .sel_load(b_sel_load),
    .dwell(4'd0), .din(b_din), .out_ready(1'b1), .out_valid(b_out_valid),
    .dout(b_dout), .out_ch(b_out_ch), .sel_cur(b_sel_cur), .sel_err(b_sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies the behavioural rules to the inputs present at this edge.
  task automatic model_tick();
    int take, base;
    if (rst) begin
      m_valid = 0; m_dout = 0; m_ch = 0; m_sel = 0; m_err = 0; m_cnt = 0; m_mprev = 0;
      return;
    end
    take  = (en && (!m_valid || out_ready)) ? 1 : 0;
    m_err = (mode == 1'b0 && sel_load && int'(sel_in) >= N) ? 1 : 0;
    if (take != 0) begin
      m_dout  = (m_sel < N) ? int'(din[m_sel*W +: W]) : 0;
      m_ch    = m_sel;
      m_valid = 1;
    end else if (m_valid != 0 && out_ready) begin
      m_valid = 0;
    end
    if (mode == 1'b0) begin
      m_cnt = 0;
      if (sel_load && int'(sel_in) < N) m_sel = int'(sel_in);
    end else begin
      base = (int'(mode) != m_mprev) ? 0 : m_cnt;
      if (take != 0) begin
        if (base == int'(dwell)) begin
          m_cnt = 0;
          m_sel = (m_sel + 1) % N;
        end else begin
          m_cnt = (base + 1) % (1 << DW);
        end
      end else begin
        m_cnt = base;
      end
    end
    m_mprev = int'(mode);
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    chk_eq("out_valid", 32'(out_valid), m_valid);
    chk_eq("dout",      32'(dout),      m_dout);
    chk_eq("out_ch",    32'(out_ch),    m_ch);
    chk_eq("sel_cur",   32'(sel_cur),   m_sel);
    chk_eq("sel_err",   32'(sel_err),   m_err);
  endtask

  logic [N*W-1:0] pat;
  int scan_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    pat = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel_load = 1'b0; sel_in = '0;
    dwell = '0; din = '1; out_ready = 1'b1;
    b_rst = 1'b1; b_sel_load = 1'b0; b_sel_in = '0; b_din = {8'h33, 8'h22, 8'h11};

    // Reset with all-ones data
    step(); step();
    chk_eq("rst_valid", 32'(out_valid), 0);
    chk_eq("rst_dout",  32'(dout), 0);
    chk_eq("rst_sel",   32'(sel_cur), 0);
    chk_eq("rst_ch",    32'(out_ch), 0);
    chk_eq("rst_err",   32'(sel_err), 0);

    // Manual select: load takes effect on the following capture
    rst = 1'b0; din = pat; sel_load = 1'b1; sel_in = 2'd2;
    step();
    chk_eq("man_load_dout", 32'(dout), 32'hAA);
    chk_eq("man_load_ch",   32'(out_ch), 0);
    chk_eq("man_load_sel",  32'(sel_cur), 2);
    sel_load = 1'b0;
    step();
    chk_eq("man_next_dout", 32'(dout), 32'hCC);
    chk_eq("man_next_ch",   32'(out_ch), 2);

    // Out-of-range select on a 3-channel instance
    b_rst = 1'b0; b_sel_load = 1'b1; b_sel_in = 2'd2;
    step();
    chk_eq("b_load_sel", 32'(b_sel_cur), 2);
    chk_eq("b_load_err", 32'(b_sel_err), 0);
    b_sel_in = 2'd3;
    step();
    chk_eq("b_oor_err", 32'(b_sel_err), 1);
    chk_eq("b_oor_sel", 32'(b_sel_cur), 2);
    b_sel_load = 1'b0;
    step();
    chk_eq("b_err_clear", 32'(b_sel_err), 0);
    chk_eq("b_sel_hold",  32'(b_sel_cur), 2);
    chk_eq("b_dout",      32'(b_dout), 32'h33);
    chk_eq("b_ch",        32'(b_out_ch), 2);

    // Scan with dwell=1
    rst = 1'b1; step();
    rst = 1'b0; mode = 1'b1; dwell = 4'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_eq("scan_dw1_ch", 32'(out_ch), scan_exp[i]);
    end

    // Backpressure with dwell=0
    rst = 1'b1; step();
    rst = 1'b0; dwell = 4'd0; din = pat;
    step();
    chk_eq("bp_first_ch", 32'(out_ch), 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = {$urandom, $urandom} & {N*W{1'b1}};
      step();
      chk_eq("bp_hold_dout", 32'(dout), 32'hAA);
      chk_eq("bp_hold_ch",   32'(out_ch), 0);
      chk_eq("bp_hold_sel",  32'(sel_cur), 1);
    end
    out_ready = 1'b1; din = pat;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_eq("bp_resume_ch", 32'(out_ch), i % N);
    end

    // Reset mid-scan with dwell=1
    rst = 1'b1; step();
    rst = 1'b0; dwell = 4'd1;
    for (int i = 0; i < 4; i++) step();
    chk_eq("mid_pre_sel",   32'(sel_cur), 2);
    chk_eq("mid_pre_valid", 32'(out_valid), 1);
    rst = 1'b1; step();
    chk_eq("mid_rst_valid", 32'(out_valid), 0);
    chk_eq("mid_rst_sel",   32'(sel_cur), 0);
    rst = 1'b0;
    step(); chk_eq("mid_restart0", 32'(out_ch), 0);
    step(); chk_eq("mid_restart1", 32'(out_ch), 0);
    step(); chk_eq("mid_restart2", 32'(out_ch), 1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      en        = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      sel_load  = ($urandom_range(0, 3) == 0);
      sel_in    = SW'($urandom_range(0, N - 1));
      din       = {$urandom, $urandom} & {N*W{1'b1}};
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0) dwell = DW'($urandom_range(0, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
